// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one single-word sdram_ctrl request interface
// among NumPorts requesters, one transaction in flight, read data routed to owner.
module sdram_port_arbiter #(
    parameter int NumPorts  = 3,
    parameter int AddrWidth = 22,
    parameter int DataWidth = 16,
    parameter int RdTimeout = 64
) (
    input  logic                           i_sys_clk,
    input  logic                           i_rst,
    input  logic [NumPorts-1:0]            i_req,
    input  logic [NumPorts-1:0]            i_we,
    input  logic [NumPorts*AddrWidth-1:0]  i_addr,
    input  logic [NumPorts*DataWidth-1:0]  i_wdata,
    output logic [NumPorts-1:0]            o_gnt,
    output logic [NumPorts-1:0]            o_rd_valid,
    output logic [NumPorts-1:0]            o_rd_err,
    output logic [DataWidth-1:0]           o_rd_data,
    output logic                           o_ctrl_wr_req,
    output logic                           o_ctrl_rd_req,
    output logic [AddrWidth-1:0]           o_ctrl_addr,
    output logic [DataWidth-1:0]           o_ctrl_wdata,
    input  logic                           i_ctrl_ready,
    input  logic                           i_ctrl_rd_valid,
    input  logic [DataWidth-1:0]           i_ctrl_rd_data
);

    localparam int IdxW = $clog2(NumPorts);
    localparam int CntW = $clog2(RdTimeout) + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WR_WAIT = 2'd2,
        RD_WAIT = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [IdxW-1:0]       ptr_q, ptr_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic                  we_q, we_d;
    logic                  holdoff_q, holdoff_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [NumPorts-1:0]   gnt_q, gnt_d;
    logic [NumPorts-1:0]   rd_valid_q, rd_valid_d;
    logic [NumPorts-1:0]   rd_err_q, rd_err_d;
    logic [DataWidth-1:0]  rd_data_q, rd_data_d;
    logic                  wr_req_q, wr_req_d;
    logic                  rd_req_q, rd_req_d;
    logic [AddrWidth-1:0]  addr_q, addr_d;
    logic [DataWidth-1:0]  wdata_q, wdata_d;

    logic                  sel_found_s;
    logic [IdxW-1:0]       sel_idx_s;
    logic [IdxW:0]         cand_s;

    // Round-robin pick: scan downward so the candidate nearest the pointer wins.
    always_comb begin
        sel_found_s = 1'b0;
        sel_idx_s   = '0;
        cand_s      = '0;
        for (int k = NumPorts - 1; k >= 0; k--) begin
            cand_s = {1'b0, ptr_q} + (IdxW + 1)'(k);
            if (cand_s >= (IdxW + 1)'(NumPorts)) begin
                cand_s = cand_s - (IdxW + 1)'(NumPorts);
            end else begin
                cand_s = cand_s;
            end
            if (i_req[cand_s[IdxW-1:0]]) begin
                sel_found_s = 1'b1;
                sel_idx_s   = cand_s[IdxW-1:0];
            end else begin
                sel_found_s = sel_found_s;
            end
        end
    end

    // Next-state and registered-output computation for the transaction FSM.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        idx_d      = idx_q;
        we_d       = we_q;
        holdoff_d  = holdoff_q;
        cnt_d      = cnt_q;
        gnt_d      = '0;
        rd_valid_d = '0;
        rd_err_d   = '0;
        rd_data_d  = rd_data_q;
        wr_req_d   = 1'b0;
        rd_req_d   = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        case (state_q)
            IDLE: begin
                if (sel_found_s && i_ctrl_ready) begin
                    idx_d            = sel_idx_s;
                    we_d             = i_we[sel_idx_s];
                    addr_d           = i_addr[sel_idx_s*AddrWidth +: AddrWidth];
                    wdata_d          = i_wdata[sel_idx_s*DataWidth +: DataWidth];
                    gnt_d[sel_idx_s] = 1'b1;
                    ptr_d            = (sel_idx_s == IdxW'(NumPorts - 1)) ? '0 : sel_idx_s + IdxW'(1);
                    state_d          = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (we_q) begin
                    wr_req_d  = 1'b1;
                    holdoff_d = 1'b1;
                    state_d   = WR_WAIT;
                end else begin
                    rd_req_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = RD_WAIT;
                end
            end
            WR_WAIT: begin
                // The controller may still report ready in the cycle it sees our request.
                if (holdoff_q) begin
                    holdoff_d = 1'b0;
                end else if (i_ctrl_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = WR_WAIT;
                end
            end
            RD_WAIT: begin
                if (i_ctrl_rd_valid) begin
                    rd_data_d         = i_ctrl_rd_data;
                    rd_valid_d[idx_q] = 1'b1;
                    cnt_d             = '0;
                    state_d           = IDLE;
                end else if (cnt_q == CntW'(RdTimeout - 1)) begin
                    rd_err_d[idx_q] = 1'b1;
                    cnt_d           = '0;
                    state_d         = IDLE;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            idx_q      <= '0;
            we_q       <= 1'b0;
            holdoff_q  <= 1'b0;
            cnt_q      <= '0;
            gnt_q      <= '0;
            rd_valid_q <= '0;
            rd_err_q   <= '0;
            rd_data_q  <= '0;
            wr_req_q   <= 1'b0;
            rd_req_q   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            idx_q      <= idx_d;
            we_q       <= we_d;
            holdoff_q  <= holdoff_d;
            cnt_q      <= cnt_d;
            gnt_q      <= gnt_d;
            rd_valid_q <= rd_valid_d;
            rd_err_q   <= rd_err_d;
            rd_data_q  <= rd_data_d;
            wr_req_q   <= wr_req_d;
            rd_req_q   <= rd_req_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign o_gnt         = gnt_q;
    assign o_rd_valid    = rd_valid_q;
    assign o_rd_err      = rd_err_q;
    assign o_rd_data     = rd_data_q;
    assign o_ctrl_wr_req = wr_req_q;
    assign o_ctrl_rd_req = rd_req_q;
    assign o_ctrl_addr   = addr_q;
    assign o_ctrl_wdata  = wdata_q;

endmodule
